num_led_to_xy: RTL and testbench

Inverse LED-index mapper for the WS2812B matrix path: accepts a linear strip index and returns the matrix (x, y) coordinate it drives, undoing the serpentine row wiring. Division by the matrix width is done by iterative subtraction, so no hardware divider is needed. Results are handed over on a valid/ready pair. It sits between the strip frame scanner, which walks indices 0..N-1, and the pixel/pattern generator, which works in XY space.

---
 rtl/num_led_to_xy.sv | 93 +++++++++
 tb/tb_num_led_to_xy.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/num_led_to_xy.sv
// num_led_to_xy: strip index -> matrix (x, y) via iterative subtraction; XY_SERPENTINE_EN mirrors odd rows
module num_led_to_xy #(
    parameter int MATRIX_W = 5,
    parameter int MATRIX_H = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] num_led,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic [1:0] {IDLE, DIV, MAP, DONE} state_t;
    localparam logic [8:0] W_C = 9'(MATRIX_W);
    localparam logic [8:0] N_C = 9'(MATRIX_W * MATRIX_H);
    state_t     state, state_d;
    logic [7:0] rem, rem_d;
    logic [3:0] row, row_d, x_d, y_d, x_map;
    logic       err_d, ov_d;
    assign in_ready = state == IDLE && !rst;
`ifdef XY_SERPENTINE_EN
    localparam logic [3:0] W_M1 = 4'(MATRIX_W - 1);
    // rem < MATRIX_W here, so the mirror cannot underflow
    assign x_map = row[0] ? W_M1 - rem[3:0] : rem[3:0];
`else
    assign x_map = rem[3:0];
`endif
    always_comb begin
        state_d = state;
        rem_d   = rem;
        row_d   = row;
        x_d     = x;
        y_d     = y;
        err_d   = err;
        ov_d    = out_valid;
        case (state)
            IDLE: if (in_valid) begin
                rem_d = num_led;
                row_d = '0;
                if ({1'b0, num_led} >= N_C) begin
                    x_d     = '0;
                    y_d     = '0;
                    err_d   = 1'b1;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d   = 1'b0;
                    state_d = DIV;
                end
            end
            DIV: if ({1'b0, rem} >= W_C) begin
                rem_d = rem - W_C[7:0];
                row_d = row + 4'd1;
            end else begin
                state_d = MAP;
            end
            MAP: begin
                x_d     = x_map;
                y_d     = row;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            row       <= '0;
            x         <= '0;
            y         <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            rem       <= rem_d;
            row       <= row_d;
            x         <= x_d;
            y         <= y_d;
            err       <= err_d;
            out_valid <= ov_d;
        end
    end
endmodule

// File: tb/tb_num_led_to_xy.sv
// tb_num_led_to_xy: randomized scoreboard bench for num_led_to_xy against a div/mod reference model
module tb_num_led_to_xy;
    localparam int W = 5;
    localparam int H = 5;
`ifdef XY_SERPENTINE_EN
    localparam bit SERP = 1'b1;
`else
    localparam bit SERP = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] num_led = '0;
    logic       in_valid = 1'b0, in_ready;
    logic [3:0] x, y;
    logic       err, out_valid;
    logic       out_ready = 1'b1;

    always #5 clk = ~clk;

    num_led_to_xy #(.MATRIX_W(W), .MATRIX_H(H)) dut (
        .clk(clk), .rst(rst), .num_led(num_led), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .err(err), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0, acc_edge = 0, lat_seen = 0;
    int   hits[W*H];
    bit   prev_ov = 1'b0, sweep = 1'b0, rand_rdy = 1'b0;

    function automatic exp_t model(input int idx);
        exp_t e;
        int   r, c;
        r = idx / W;
        c = idx % W;
        if (idx >= W * H) begin
            e.x = '0; e.y = '0; e.err = 1'b1; e.lat = -1;
        end else begin
            e.y   = 4'(r);
            e.x   = 4'((SERP && (r % 2 == 1)) ? W - 1 - c : c);
            e.err = 1'b0;
            e.lat = r + 2;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rand_rdy) #2 out_ready = ($urandom_range(0, 3) != 0);

    // monitor: latency is measured from the accept edge to the first edge showing out_valid
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (in_valid && in_ready) acc_edge = cyc + 1;
            if (out_valid && !prev_ov) lat_seen = cyc - acc_edge;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: x=%0d y=%0d err=%0d with empty scoreboard", x, y, err);
                end else begin
                    e = sb.pop_front();
                    chk("x", int'(x), int'(e.x));
                    chk("y", int'(y), int'(e.y));
                    chk("err", int'(err), int'(e.err));
                    if (e.lat < 0) chk("lat_oor_le1", int'(lat_seen <= 1), 1);
                    else chk("lat", lat_seen, e.lat);
                    if (sweep && !err && x < W && y < H) hits[int'(y) * W + int'(x)]++;
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic send(input logic [7:0] idx, input bit hold);
        int n = 0;
        num_led  = idx;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: idx=%0d in_ready=%0d expected 1", idx, in_ready);
        end else begin
            sb.push_back(model(int'(idx)));
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e13;
        int   n, bad;
        repeat (3) @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send(8'd0, 1'b0);
        send(8'd6, 1'b0);
        send(8'd24, 1'b0);
        send(8'd25, 1'b0);
        drain();
        // backpressure on idx 13
        out_ready = 1'b0;
        e13 = model(13);
        send(8'd13, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_x", int'(x), int'(e13.x));
            chk("bp_y", int'(y), int'(e13.y));
            chk("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        // reset while dividing
        send(8'd20, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_x", int'(x), 0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send(8'd20, 1'b0);
        drain();
        // back-to-back sweep with in_valid held
        for (int i = 0; i < W * H; i++) hits[i] = 0;
        sweep = 1'b1;
        for (int i = 0; i < W * H; i++) send(8'(i), i != W * H - 1);
        drain();
        sweep = 1'b0;
        bad = 0;
        for (int i = 0; i < W * H; i++) if (hits[i] != 1) bad++;
        chk("sweep_bijection_bad_cells", bad, 0);
        // random indices with random backpressure
        rand_rdy = 1'b1;
        repeat (40) send(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, W * H + 2)), 1'b0);
        drain();
        rand_rdy = 1'b0;
        #3 out_ready = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
